// File: rtl/ex_trap_plic_if.sv
// AXI4-Lite configuration port of the external-interrupt controller.
// The slave side is ex_trap_plic; the master side is the system bus or a bench.
interface ex_trap_plic_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ex_trap_plic.sv
// External-interrupt controller: synchronises CH_NUM lines, arbitrates by priority
// above a threshold, raises one trap to the core and tracks a single in-service claim.
module ex_trap_plic #(
    parameter int CH_NUM = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] irq_i,
    output logic              trap_valid_o,
    input  logic              trap_ready_i,
    output logic [4:0]        claim_id_o,
    ex_trap_plic_if.slave     plic_axi
);
    if (CH_NUM < 1 || CH_NUM > 24 || PRIO_W < 1 || PRIO_W > 8) begin : g_cfg_err
        $error("ex_trap_plic: CH_NUM must be 1..24 and PRIO_W 1..8");
    end

    localparam logic [5:0] A_PENDING = 6'h00;
    localparam logic [5:0] A_ENABLE  = 6'h01;
    localparam logic [5:0] A_MODE    = 6'h02;
    localparam logic [5:0] A_THRESH  = 6'h03;
    localparam logic [5:0] A_CLAIM   = 6'h04;
    localparam logic [5:0] A_PRIO    = 6'h08;

    logic [CH_NUM-1:0] sync1, sync2, sync3, pending, enable, mode;
    logic [PRIO_W-1:0] threshold;
    logic [PRIO_W-1:0] prio [CH_NUM];
    logic              busy, best_hit, accept, complete, wr_fire, rd_fire;
    logic [4:0]        claim_id, best_id, best_id_q;
    logic [5:0]        wr_idx, rd_idx;
    logic [31:0]       rd_mux;
    logic              unused_ok;

    assign wr_fire  = plic_axi.awvalid && plic_axi.wvalid && !plic_axi.bvalid;
    assign rd_fire  = plic_axi.arvalid && !plic_axi.rvalid;
    assign wr_idx   = plic_axi.awaddr[7:2];
    assign rd_idx   = plic_axi.araddr[7:2];

    assign plic_axi.awready = wr_fire;
    assign plic_axi.wready  = wr_fire;
    assign plic_axi.arready = rd_fire;
    assign plic_axi.bresp   = 2'b00;
    assign plic_axi.rresp   = 2'b00;

    assign accept     = trap_valid_o && trap_ready_i;
    assign complete   = wr_fire && (wr_idx == A_CLAIM) && busy && (plic_axi.wdata[4:0] == claim_id);
    assign claim_id_o = claim_id;

    // Strict '>' keeps the earliest (lowest ID) channel on priority ties.
    always_comb begin
        logic [PRIO_W-1:0] best_prio;
        best_hit  = 1'b0;
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) &&
                (!best_hit || (prio[i] > best_prio))) begin
                best_hit  = 1'b1;
                best_id   = 5'(i + 1);
                best_prio = prio[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            A_PENDING: rd_mux[CH_NUM-1:0] = pending;
            A_ENABLE:  rd_mux[CH_NUM-1:0] = enable;
            A_MODE:    rd_mux[CH_NUM-1:0] = mode;
            A_THRESH:  rd_mux[PRIO_W-1:0] = threshold;
            A_CLAIM:   rd_mux[4:0]        = claim_id;
            default: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (rd_idx == A_PRIO + 6'(i)) rd_mux[PRIO_W-1:0] = prio[i];
                end
            end
        endcase
    end

    // NOTE: the register file is tiny and must read back 0 after reset, so the PRIO array is reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable          <= '0;
            mode            <= '0;
            threshold       <= '0;
            for (int i = 0; i < CH_NUM; i++) prio[i] <= '0;
            plic_axi.bvalid <= 1'b0;
            plic_axi.rvalid <= 1'b0;
            plic_axi.rdata  <= '0;
        end else begin
            if (wr_fire) begin
                plic_axi.bvalid <= 1'b1;
                case (wr_idx)
                    A_ENABLE: enable    <= plic_axi.wdata[CH_NUM-1:0];
                    A_MODE:   mode      <= plic_axi.wdata[CH_NUM-1:0];
                    A_THRESH: threshold <= plic_axi.wdata[PRIO_W-1:0];
                    default: begin
                        for (int i = 0; i < CH_NUM; i++) begin
                            if (wr_idx == A_PRIO + 6'(i)) prio[i] <= plic_axi.wdata[PRIO_W-1:0];
                        end
                    end
                endcase
            end else if (plic_axi.bready) begin
                plic_axi.bvalid <= 1'b0;
            end

            if (rd_fire) begin
                plic_axi.rvalid <= 1'b1;
                plic_axi.rdata  <= rd_mux;
            end else if (plic_axi.rready) begin
                plic_axi.rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            pending      <= '0;
            busy         <= 1'b0;
            claim_id     <= '0;
            best_id_q    <= '0;
            trap_valid_o <= 1'b0;
        end else begin
            sync1 <= irq_i;
            sync2 <= sync1;
            sync3 <= sync2;
            for (int i = 0; i < CH_NUM; i++) begin
                if (!mode[i])                             pending[i] <= sync2[i];
                else if (sync2[i] && !sync3[i])           pending[i] <= 1'b1;
                else if (accept && best_id_q == 5'(i + 1)) pending[i] <= 1'b0;
            end
            // Completion is applied first so a coinciding acceptance wins the claim.
            if (complete) begin
                busy     <= 1'b0;
                claim_id <= '0;
            end
            if (accept) begin
                busy     <= 1'b1;
                claim_id <= best_id_q;
            end
            // NOTE: busy is only set on this edge, so the acceptance itself must also drop valid.
            trap_valid_o <= best_hit && !busy && !accept;
            best_id_q    <= best_id;
        end
    end

    assign unused_ok = ^{plic_axi.awaddr, plic_axi.araddr, plic_axi.awprot, plic_axi.arprot,
                         plic_axi.wstrb, plic_axi.wdata};
endmodule

// File: tb/tb_ex_trap_plic.sv
// Directed bench for ex_trap_plic: register access, latency, arbitration,
// threshold, claim/complete and AXI back-pressure and reset abort.
module tb_ex_trap_plic;
    localparam int CH_NUM = 8;
    localparam int PRIO_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH_NUM-1:0] irq;
    logic              trap_valid;
    logic              trap_ready;
    logic [4:0]        claim_id;
    int                total = 0;
    int                bad   = 0;

    ex_trap_plic_if plic_axi ();

    ex_trap_plic #(.CH_NUM(CH_NUM), .PRIO_W(PRIO_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq),
        .trap_valid_o (trap_valid),
        .trap_ready_i (trap_ready),
        .claim_id_o   (claim_id),
        .plic_axi     (plic_axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        plic_axi.awaddr  = 32'(addr);
        plic_axi.wdata   = data;
        plic_axi.awvalid = 1'b1;
        plic_axi.wvalid  = 1'b1;
        plic_axi.bready  = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!plic_axi.bvalid && n < 20);
        plic_axi.awvalid = 1'b0;
        plic_axi.wvalid  = 1'b0;
        if (!plic_axi.bvalid) check("wr_timeout", 32'(plic_axi.bvalid), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        plic_axi.araddr  = 32'(addr);
        plic_axi.arvalid = 1'b1;
        plic_axi.rready  = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!plic_axi.rvalid && n < 20);
        plic_axi.arvalid = 1'b0;
        if (!plic_axi.rvalid) check({tag, "_timeout"}, 32'(plic_axi.rvalid), 32'd1);
        else                  check(tag, plic_axi.rdata, exp);
        @(negedge clk);
    endtask

    task automatic wait_trap(input int budget);
        int n = 0;
        while (!trap_valid && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("trap_wait", 32'(trap_valid), 32'd1);
    endtask

    task automatic accept_trap();
        @(negedge clk);
        trap_ready = 1'b1;
        @(posedge clk); #1;
        trap_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] regs [8];
        int e;
        regs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h3C, 8'h14};
        rst = 1'b1; irq = '0; trap_ready = 1'b0;
        plic_axi.awaddr = '0; plic_axi.awprot = '0; plic_axi.awvalid = 1'b0;
        plic_axi.wdata  = '0; plic_axi.wstrb  = 4'hF; plic_axi.wvalid = 1'b0;
        plic_axi.bready = 1'b0; plic_axi.araddr = '0; plic_axi.arprot = '0;
        plic_axi.arvalid = 1'b0; plic_axi.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(trap_valid), 32'd0);
        check("rst_claim", 32'(claim_id), 32'd0);
        check("rst_bvalid", 32'(plic_axi.bvalid), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) check_reg($sformatf("rst_reg_%0h", regs[i]), regs[i], 32'd0);

        // Upper bits read as zero, unmapped writes are dropped.
        axi_write(8'h04, 32'hFFFF_FFFF);
        check_reg("enable_width", 8'h04, 32'h0000_00FF);
        axi_write(8'h0C, 32'hFFFF_FFFF);
        check_reg("thresh_width", 8'h0C, 32'd7);
        axi_write(8'h3C, 32'h0000_00FF);
        check_reg("prio7_width", 8'h3C, 32'd7);
        axi_write(8'h14, 32'hFFFF_FFFF);
        check_reg("unmapped", 8'h14, 32'd0);
        axi_write(8'h04, 32'd0);
        axi_write(8'h0C, 32'd0);
        axi_write(8'h3C, 32'd0);

        // Channel 3 edge mode: single-cycle pulse, four-edge latency.
        axi_write(8'h08, 32'h4);
        axi_write(8'h28, 32'd2);
        axi_write(8'h04, 32'h4);
        @(negedge clk) irq[2] = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1; e++;
            if (e == 1) irq[2] = 1'b0;
        end while (!trap_valid && e < 12);
        check("edge_latency", 32'(e), 32'd4);
        accept_trap();
        check("claim3", 32'(claim_id), 32'd3);
        check("valid_after_accept", 32'(trap_valid), 32'd0);
        check_reg("pending_cleared", 8'h00, 32'd0);
        check_reg("claim_read", 8'h10, 32'd3);
        axi_write(8'h10, 32'd2);
        check("wrong_complete", 32'(claim_id), 32'd3);

        // A new edge while busy re-sets pending and fires after completion.
        @(negedge clk) irq[2] = 1'b1;
        @(negedge clk) irq[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_no_valid", 32'(trap_valid), 32'd0);
        check_reg("pending_busy", 8'h00, 32'h4);
        axi_write(8'h10, 32'd3);
        check("complete3", 32'(claim_id), 32'd0);
        check("retrig_pre", 32'(trap_valid), 32'd0);
        @(posedge clk); #1;
        check("retrig", 32'(trap_valid), 32'd1);
        accept_trap();
        check("claim3_again", 32'(claim_id), 32'd3);
        axi_write(8'h10, 32'd3);
        check("complete3_again", 32'(claim_id), 32'd0);
        repeat (3) @(negedge clk);
        check("no_retrig", 32'(trap_valid), 32'd0);

        // Level mode arbitration: ch4 prio 7 wins, then tie between ch1 and ch6.
        axi_write(8'h08, 32'd0);
        axi_write(8'h20, 32'd5);
        axi_write(8'h34, 32'd5);
        axi_write(8'h2C, 32'd7);
        axi_write(8'h04, 32'h29);
        @(negedge clk) irq = 8'h29;
        wait_trap(10);
        accept_trap();
        check("claim_high_prio", 32'(claim_id), 32'd4);
        @(negedge clk) irq = 8'h21;
        repeat (4) @(negedge clk);
        axi_write(8'h10, 32'd4);
        check("complete4", 32'(claim_id), 32'd0);
        wait_trap(10);
        accept_trap();
        check("claim_tie_low", 32'(claim_id), 32'd1);
        @(negedge clk) irq = '0;
        repeat (4) @(negedge clk);
        axi_write(8'h10, 32'd1);
        axi_write(8'h04, 32'd0);

        // Threshold: priority equal to threshold never interrupts.
        axi_write(8'h0C, 32'd5);
        axi_write(8'h24, 32'd5);
        axi_write(8'h04, 32'h2);
        @(negedge clk) irq = 8'h02;
        repeat (8) @(negedge clk);
        check("thr_block", 32'(trap_valid), 32'd0);
        axi_write(8'h0C, 32'd4);
        check("thr_pre", 32'(trap_valid), 32'd0);
        @(posedge clk); #1;
        check("thr_after", 32'(trap_valid), 32'd1);
        accept_trap();
        check("claim2", 32'(claim_id), 32'd2);
        axi_write(8'h04, 32'd0);
        check("disable_keeps_busy", 32'(claim_id), 32'd2);
        @(negedge clk) irq = '0;
        axi_write(8'h10, 32'd2);
        check("complete2", 32'(claim_id), 32'd0);

        // Back-pressure on both channels, then reset with responses pending.
        axi_write(8'h04, 32'h1);
        @(negedge clk) irq = 8'h01;
        wait_trap(10);
        accept_trap();
        check("claim1_pre_rst", 32'(claim_id), 32'd1);
        @(negedge clk);
        plic_axi.awaddr = 32'h04; plic_axi.wdata = 32'h5;
        plic_axi.awvalid = 1'b1; plic_axi.wvalid = 1'b1; plic_axi.bready = 1'b0;
        plic_axi.araddr = 32'h0C; plic_axi.arvalid = 1'b1; plic_axi.rready = 1'b0;
        e = 0;
        do begin
            @(posedge clk); #1; e++;
        end while (!(plic_axi.bvalid && plic_axi.rvalid) && e < 10);
        check("bp_bvalid", 32'(plic_axi.bvalid), 32'd1);
        check("bp_rvalid", 32'(plic_axi.rvalid), 32'd1);
        check("bp_rdata", plic_axi.rdata, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", 32'(plic_axi.bvalid), 32'd1);
            check("hold_rvalid", 32'(plic_axi.rvalid), 32'd1);
            check("hold_awready", 32'(plic_axi.awready), 32'd0);
            check("hold_arready", 32'(plic_axi.arready), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("rst_bvalid_drop", 32'(plic_axi.bvalid), 32'd0);
        check("rst_rvalid_drop", 32'(plic_axi.rvalid), 32'd0);
        check("rst_claim_lost", 32'(claim_id), 32'd0);
        check("rst_valid_drop", 32'(trap_valid), 32'd0);
        plic_axi.awvalid = 1'b0; plic_axi.wvalid = 1'b0; plic_axi.arvalid = 1'b0;
        irq = '0;
        @(negedge clk) rst = 1'b0;
        check_reg("post_rst_enable", 8'h04, 32'd0);
        check_reg("post_rst_thresh", 8'h0C, 32'd0);
        check_reg("post_rst_prio0", 8'h20, 32'd0);
        check_reg("post_rst_pending", 8'h00, 32'd0);
        check_reg("post_rst_claim", 8'h10, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
